regfile_scb: RTL and testbench
==============================

Name: regfile_scb

Overview:
Parametrised multi-port register file, successor to the 8x16 two-read/one-write regFile. Adds configurable width and depth, an optional hardwired-zero register, write-to-read bypass, and a per-register pending scoreboard. The pipeline decode stage uses it to read operands and detect RAW hazards. Writeback writes results into it and clears the scoreboard.

Parameters:
WIDTH, 16, data width of each register
ADDR_W, 3, select width; DEPTH = 2**ADDR_W registers
ZERO_REG, 0, 1 = register 0 reads as 0, ignores writes, never pending
BYPASS, 1, 1 = same-cycle write data forwarded to read ports
SCB_CHECK, 1, 1 = protocol violations set err

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  synchronous reset, active low
rd1_sel  in  ADDR_W  read port 1 select
rd2_sel  in  ADDR_W  read port 2 select
rd1_data  out  WIDTH  read port 1 data (combinational)
rd2_data  out  WIDTH  read port 2 data (combinational)
rd1_pending  out  1  register at rd1_sel awaits writeback
rd2_pending  out  1  register at rd2_sel awaits writeback
wr_en  in  1  writeback enable
wr_sel  in  ADDR_W  writeback select
wr_data  in  WIDTH  writeback data
rsv_en  in  1  reserve destination (instruction issued)
rsv_sel  in  ADDR_W  register to reserve
err  out  1  sticky protocol error, registered

Behaviour:
- Reset: the clock and reset are fixed as one clock (clk) and a synchronous, active-low reset (rst_n). rst_n=0 at a rising edge clears all registers to 0, all pending bits to 0, and err to 0. Writes and reservations in that cycle are ignored. Reset mid-sequence discards all outstanding reservations.
- Write: at a rising edge with rst_n=1 and wr_en=1, reg[wr_sel] <= wr_data. Other registers hold their value. With ZERO_REG=1 and wr_sel=0, the write is dropped silently.
- Read: rdN_data = reg[rdN_sel], with zero latency.
  - With BYPASS=1, wr_en=1 and wr_sel==rdN_sel, rdN_data = wr_data.
  - ZERO_REG=1 with rdN_sel=0 always gives 0; this overrides bypass.
  - Both ports may select the same register; each returns identical data.
- Scoreboard: one pending bit per register.
  - Next-state clear: wr_en clears pending[wr_sel].
  - Next-state set: rsv_en sets pending[rsv_sel].
  - Same index written and reserved in one cycle: set wins (a new producer has issued); no error.
  - Different indices in one cycle: both take effect.
  - ZERO_REG=1: pending[0] is forced to 0.
- Pending outputs: rdN_pending = pending[rdN_sel].
  - With BYPASS=1, the output is masked to 0 when wr_en=1 and wr_sel==rdN_sel, because the data is available that cycle.
  - A reservation in the current cycle is not visible until the next cycle.
- err: applies only when SCB_CHECK=1. Set on a rising edge (rst_n=1) when either condition holds:
  - (a) wr_en=1 to a register that is not pending, excluding register 0 when ZERO_REG=1;
  - (b) rsv_en=1 to a register already pending that is not cleared by a same-cycle write (WAW without retire).
  - err is also set when wr_en or rsv_en is X at the edge (simulation only).
  - err stays at 1 until reset. With SCB_CHECK=0, err is held at 0.
- Widths: selects are unsigned, so there is no out-of-range case. No arithmetic is performed on data.

Test Plan:
- Reset, then read all 8 registers -> all rdN_data=0x0000, rdN_pending=0, err=0.
- Cycle 0: rsv r3. Cycle 1: rd1_sel=3 -> rd1_pending=1. Cycle 2: wr r3=0xBEEF with rd1_sel=3 -> rd1_data=0xBEEF (bypass), rd1_pending=0 in the same cycle. Cycle 3: rd1_data=0xBEEF, pending=0.
- ZERO_REG=1: rsv r0 then wr r0=0x1234 -> rd2_sel=0 gives 0x0000, rd2_pending=0, err=0.
- Same cycle: wr r5=0x0055 and rsv r5, with r5 previously pending -> next cycle reg5=0x0055, pending[5]=1, err=0.
- SCB_CHECK=1: wr r2 without prior reservation -> err=1 next cycle and stays 1 across 10 idle cycles. Assert rst_n=0 for one edge -> err=0.
- WIDTH=32, ADDR_W=4: write 0xDEADBEEF to r15 -> read on both ports next cycle gives 0xDEADBEEF; rsv r15 twice without a write -> err=1.

Source files
------------

// File: rtl/regfile_scb.sv
// Parametrised multi-port register file with write-to-read bypass and a
// per-register pending scoreboard used by decode for RAW hazard detection.
module regfile_scb #(
    parameter int WIDTH     = 16,
    parameter int ADDR_W    = 3,
    parameter int ZERO_REG  = 0,
    parameter int BYPASS    = 1,
    parameter int SCB_CHECK = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd1_sel,
    input  logic [ADDR_W-1:0] rd2_sel,
    output logic [WIDTH-1:0]  rd1_data,
    output logic [WIDTH-1:0]  rd2_data,
    output logic              rd1_pending,
    output logic              rd2_pending,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_sel,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_sel,
    output logic              err
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] pending_q, pending_d;
    logic             err_q, err_d;
    logic             wr_is_zero;
    logic             wr_err, rsv_err;

    assign wr_is_zero = (ZERO_REG != 0) && (wr_sel == '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en && !wr_is_zero) begin
            regs_d[wr_sel] = wr_data;
        end
    end

    // A reservation issued alongside a retiring write to the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (wr_en) begin
            pending_d[wr_sel] = 1'b0;
        end
        if (rsv_en) begin
            pending_d[rsv_sel] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pending_d[0] = 1'b0;
        end
    end

    always_comb begin
        wr_err  = wr_en && !pending_q[wr_sel] && !wr_is_zero;
        rsv_err = rsv_en && pending_q[rsv_sel] && !(wr_en && (wr_sel == rsv_sel));
        err_d   = err_q;
        if (SCB_CHECK != 0) begin
            if (wr_err || rsv_err || $isunknown({wr_en, rsv_en})) begin
                err_d = 1'b1;
            end
        end else begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    // Hardwired zero takes priority over bypass so register 0 never leaks write data.
    always_comb begin
        rd1_data    = regs_q[rd1_sel];
        rd1_pending = pending_q[rd1_sel];
        if ((BYPASS != 0) && wr_en && (wr_sel == rd1_sel)) begin
            rd1_data    = wr_data;
            rd1_pending = 1'b0;
        end
        if ((ZERO_REG != 0) && (rd1_sel == '0)) begin
            rd1_data    = '0;
            rd1_pending = 1'b0;
        end

        rd2_data    = regs_q[rd2_sel];
        rd2_pending = pending_q[rd2_sel];
        if ((BYPASS != 0) && wr_en && (wr_sel == rd2_sel)) begin
            rd2_data    = wr_data;
            rd2_pending = 1'b0;
        end
        if ((ZERO_REG != 0) && (rd2_sel == '0)) begin
            rd2_data    = '0;
            rd2_pending = 1'b0;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_regfile_scb.sv
// Directed-vector bench for regfile_scb: default 8x16 instance plus a
// 16x32 instance with a hardwired zero register.
module tb_regfile_scb;
    logic clk = 1'b0;
    logic rst_n;

    logic [2:0]  rd1_sel, rd2_sel, wr_sel, rsv_sel;
    logic [15:0] rd1_data, rd2_data, wr_data;
    logic        rd1_pending, rd2_pending, wr_en, rsv_en, err;

    logic [3:0]  b_rd1_sel, b_rd2_sel, b_wr_sel, b_rsv_sel;
    logic [31:0] b_rd1_data, b_rd2_data, b_wr_data;
    logic        b_rd1_pending, b_rd2_pending, b_wr_en, b_rsv_en, b_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_scb u_dut (
        .clk(clk), .rst_n(rst_n),
        .rd1_sel(rd1_sel), .rd2_sel(rd2_sel),
        .rd1_data(rd1_data), .rd2_data(rd2_data),
        .rd1_pending(rd1_pending), .rd2_pending(rd2_pending),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_sel(rsv_sel), .err(err)
    );

    regfile_scb #(.WIDTH(32), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1), .SCB_CHECK(1)) u_dut_wide (
        .clk(clk), .rst_n(rst_n),
        .rd1_sel(b_rd1_sel), .rd2_sel(b_rd2_sel),
        .rd1_data(b_rd1_data), .rd2_data(b_rd2_data),
        .rd1_pending(b_rd1_pending), .rd2_pending(b_rd2_pending),
        .wr_en(b_wr_en), .wr_sel(b_wr_sel), .wr_data(b_wr_data),
        .rsv_en(b_rsv_en), .rsv_sel(b_rsv_sel), .err(b_err)
    );

    typedef struct {
        logic        wr_en;
        logic [2:0]  wr_sel;
        logic [15:0] wr_data;
        logic        rsv_en;
        logic [2:0]  rsv_sel;
        logic [2:0]  rd1_sel;
        logic [2:0]  rd2_sel;
        logic [15:0] e_d1;
        logic [15:0] e_d2;
        logic        e_p1;
        logic        e_p2;
        logic        e_err;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic we, input int ws, input logic [15:0] wd,
                                input logic re, input int rs, input int r1, input int r2,
                                input logic [15:0] d1, input logic [15:0] d2,
                                input logic p1, input logic p2);
        vec_t v;
        v.wr_en = we;  v.wr_sel = 3'(ws);  v.wr_data = wd;
        v.rsv_en = re; v.rsv_sel = 3'(rs);
        v.rd1_sel = 3'(r1); v.rd2_sel = 3'(r2);
        v.e_d1 = d1; v.e_d2 = d2; v.e_p1 = p1; v.e_p2 = p2; v.e_err = 1'b0;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        wr_en = v.wr_en; wr_sel = v.wr_sel; wr_data = v.wr_data;
        rsv_en = v.rsv_en; rsv_sel = v.rsv_sel;
        rd1_sel = v.rd1_sel; rd2_sel = v.rd2_sel;
    endtask

    task automatic idle_main();
        wr_en = 1'b0; rsv_en = 1'b0; wr_sel = '0; wr_data = '0; rsv_sel = '0;
    endtask

    task automatic idle_wide();
        b_wr_en = 1'b0; b_rsv_en = 1'b0; b_wr_sel = '0; b_wr_data = '0; b_rsv_sel = '0;
    endtask

    initial begin
        // Index 0-3 sweep all registers after reset; the rest walk reserve/writeback/bypass.
        vecs[0]  = mk(0, 0, 16'h0000, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0);
        vecs[1]  = mk(0, 0, 16'h0000, 0, 0, 2, 3, 16'h0000, 16'h0000, 0, 0);
        vecs[2]  = mk(0, 0, 16'h0000, 0, 0, 4, 5, 16'h0000, 16'h0000, 0, 0);
        vecs[3]  = mk(0, 0, 16'h0000, 0, 0, 6, 7, 16'h0000, 16'h0000, 0, 0);
        vecs[4]  = mk(0, 0, 16'h0000, 1, 3, 3, 3, 16'h0000, 16'h0000, 0, 0);
        vecs[5]  = mk(0, 0, 16'h0000, 0, 0, 3, 0, 16'h0000, 16'h0000, 1, 0);
        vecs[6]  = mk(1, 3, 16'hBEEF, 0, 0, 3, 3, 16'hBEEF, 16'hBEEF, 0, 0);
        vecs[7]  = mk(0, 0, 16'h0000, 0, 0, 3, 3, 16'hBEEF, 16'hBEEF, 0, 0);
        vecs[8]  = mk(0, 0, 16'h0000, 1, 5, 5, 3, 16'h0000, 16'hBEEF, 0, 0);
        vecs[9]  = mk(1, 5, 16'h0055, 1, 5, 5, 5, 16'h0055, 16'h0055, 0, 0);
        vecs[10] = mk(0, 0, 16'h0000, 0, 0, 5, 5, 16'h0055, 16'h0055, 1, 1);
        vecs[11] = mk(1, 5, 16'h1111, 1, 6, 6, 5, 16'h0000, 16'h1111, 0, 0);
        vecs[12] = mk(0, 0, 16'h0000, 0, 0, 5, 6, 16'h1111, 16'h0000, 0, 1);
        vecs[13] = mk(1, 6, 16'h6666, 0, 0, 6, 3, 16'h6666, 16'hBEEF, 0, 0);
        vecs[14] = mk(0, 0, 16'h0000, 1, 0, 0, 6, 16'h0000, 16'h6666, 0, 0);
        vecs[15] = mk(1, 0, 16'h00A0, 0, 0, 6, 0, 16'h6666, 16'h00A0, 0, 0);
        vecs[16] = mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h00A0, 16'h00A0, 0, 0);

        rst_n = 1'b0;
        idle_main(); rd1_sel = '0; rd2_sel = '0;
        idle_wide(); b_rd1_sel = '0; b_rd2_sel = '0;
        tick();
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            apply_stimulus(vecs[i]);
            #3;
            check_output($sformatf("v%0d rd1_data", i), 32'(rd1_data), 32'(vecs[i].e_d1));
            check_output($sformatf("v%0d rd2_data", i), 32'(rd2_data), 32'(vecs[i].e_d2));
            check_output($sformatf("v%0d rd1_pending", i), 32'(rd1_pending), 32'(vecs[i].e_p1));
            check_output($sformatf("v%0d rd2_pending", i), 32'(rd2_pending), 32'(vecs[i].e_p2));
            check_output($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].e_err));
            tick();
        end
        idle_main();

        // Unreserved write sets a sticky err; reset clears it and drops reservations.
        rsv_en = 1'b1; rsv_sel = 3'd1;
        tick();
        idle_main();
        wr_en = 1'b1; wr_sel = 3'd2; wr_data = 16'h0222;
        #3;
        check_output("err before unreserved write lands", 32'(err), 32'd0);
        tick();
        idle_main();
        rd1_sel = 3'd1;
        #3;
        check_output("err after unreserved write", 32'(err), 32'd1);
        check_output("r1 pending before reset", 32'(rd1_pending), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_output($sformatf("err sticky idle %0d", i), 32'(err), 32'd1);
        end
        rst_n = 1'b0;
        wr_en = 1'b1; wr_sel = 3'd7; wr_data = 16'h7777;
        rsv_en = 1'b1; rsv_sel = 3'd7;
        tick();
        rst_n = 1'b1;
        idle_main();
        rd1_sel = 3'd3; rd2_sel = 3'd7;
        #3;
        check_output("err after reset", 32'(err), 32'd0);
        check_output("r3 data after reset", 32'(rd1_data), 32'd0);
        check_output("r7 data write during reset", 32'(rd2_data), 32'd0);
        check_output("r7 pending rsv during reset", 32'(rd2_pending), 32'd0);
        rd1_sel = 3'd1;
        #1;
        check_output("r1 pending discarded by reset", 32'(rd1_pending), 32'd0);

        // Double reservation without an intervening write is a WAW error.
        tick();
        rsv_en = 1'b1; rsv_sel = 3'd4;
        tick();
        rd1_sel = 3'd4;
        #3;
        check_output("err after first rsv r4", 32'(err), 32'd0);
        check_output("r4 pending", 32'(rd1_pending), 32'd1);
        tick();
        idle_main();
        #3;
        check_output("err after WAW rsv r4", 32'(err), 32'd1);

        // Wide instance with hardwired zero register.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        b_rsv_en = 1'b1; b_rsv_sel = 4'd0;
        tick();
        idle_wide();
        b_wr_en = 1'b1; b_wr_sel = 4'd0; b_wr_data = 32'h0000_1234;
        b_rd1_sel = 4'd0; b_rd2_sel = 4'd0;
        #3;
        check_output("wide r0 bypass suppressed", b_rd2_data, 32'd0);
        check_output("wide r0 pending", 32'(b_rd2_pending), 32'd0);
        tick();
        idle_wide();
        #3;
        check_output("wide r0 after write", b_rd2_data, 32'd0);
        check_output("wide r0 rd1 after write", b_rd1_data, 32'd0);
        check_output("wide err after r0 ops", 32'(b_err), 32'd0);

        b_rsv_en = 1'b1; b_rsv_sel = 4'd15;
        tick();
        idle_wide();
        b_rd1_sel = 4'd15; b_rd2_sel = 4'd15;
        #3;
        check_output("wide r15 pending", 32'(b_rd1_pending), 32'd1);
        b_wr_en = 1'b1; b_wr_sel = 4'd15; b_wr_data = 32'hDEAD_BEEF;
        tick();
        idle_wide();
        #3;
        check_output("wide r15 rd1", b_rd1_data, 32'hDEAD_BEEF);
        check_output("wide r15 rd2", b_rd2_data, 32'hDEAD_BEEF);
        check_output("wide r15 pending cleared", 32'(b_rd2_pending), 32'd0);
        check_output("wide err after r15 write", 32'(b_err), 32'd0);

        b_rsv_en = 1'b1; b_rsv_sel = 4'd15;
        tick();
        #3;
        check_output("wide err after first rsv r15", 32'(b_err), 32'd0);
        tick();
        idle_wide();
        #3;
        check_output("wide err after WAW rsv r15", 32'(b_err), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
